// File: rtl/dsp48a1_mac_sequencer.sv
// dsp48a1_mac_sequencer: streams operand pairs into a DSP48A1 slice as a dot-product MAC.
// Define DSP_MAC_SATURATE_EN to clamp results that overflow OUT_W to all ones.
module dsp48a1_mac_sequencer #(
  parameter int LEN_W = 16,
  parameter int OUT_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OUT_W-1:0] res_data,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_cep,
  output logic             dsp_ceopmode,
  output logic             dsp_rst,
  input  logic [47:0]      dsp_p
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [LEN_W-1:0] cnt;
  logic first, v1, f1, v2, beat, drained;
  logic [OUT_W-1:0] p_out;
  assign beat = in_valid & in_ready;
  assign drained = ~v1 & ~v2;
  assign busy = state != IDLE;
  assign in_ready = state == RUN;
  assign res_valid = state == DONE;
  assign dsp_a = beat ? in_a : '0;
  assign dsp_b = beat ? in_b : '0;
  assign dsp_cea = beat;
  assign dsp_ceb = beat;
  assign dsp_cem = ~dsp_rst;
  assign dsp_ceopmode = ~dsp_rst;
  assign dsp_cep = v2;
  // First token loads P with M alone, dropping whatever the previous run left in P.
  assign dsp_opmode = v1 ? (f1 ? 8'h01 : 8'h09) : 8'h00;
`ifdef DSP_MAC_SATURATE_EN
  assign p_out = |(dsp_p >> OUT_W) ? '1 : dsp_p[OUT_W-1:0];
`else
  assign p_out = dsp_p[OUT_W-1:0];
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = start ? (len != '0 ? RUN : DONE) : IDLE;
      RUN:   state_nx = (beat && cnt == LEN_W'(1)) ? DRAIN : RUN;
      DRAIN: state_nx = drained ? DONE : DRAIN;
      DONE:  state_nx = res_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      first <= 1'b0;
      v1 <= 1'b0;
      f1 <= 1'b0;
      v2 <= 1'b0;
      res_data <= '0;
      dsp_rst <= 1'b1;
    end else begin
      state <= state_nx;
      dsp_rst <= 1'b0;
      v1 <= beat;
      f1 <= beat & first;
      v2 <= v1;
      if (state == IDLE && start) begin
        cnt <= len;
        first <= 1'b1;
        if (len == '0) res_data <= '0;
      end
      if (beat) begin
        cnt <= cnt - LEN_W'(1);
        first <= 1'b0;
      end
      if (state == DRAIN && drained) res_data <= p_out;
    end
  end
endmodule
